// File: rtl/mad_min_select.sv
// mad_min_select: running-minimum selector after the 4x4 MAD/SAD pipeline.
// Accepts one {SAD, address} word per valid cycle and tracks the smallest SAD.
// After NUM_CAND accepted candidates it reports the winner with a one-cycle
// best_valid pulse.
module mad_min_select #(
    parameter int NUM_CAND = 64,
    parameter int SAD_W    = 12,
    parameter int ADDR_W   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    in_valid,
    input  logic [SAD_W+ADDR_W:0]   mad_res,
    output logic                    busy,
    output logic                    best_valid,
    output logic [SAD_W-1:0]        best_sad,
    output logic [ADDR_W-1:0]       best_addr,
    output logic [8:0]              cand_count
);

    typedef struct packed {
        logic              rsv;
        logic [SAD_W-1:0]  sad;
        logic [ADDR_W-1:0] addr;
    } mad_word_t;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam logic [8:0] LAST_CNT = 9'(NUM_CAND);

    state_t            state, state_nxt;
    mad_word_t         word;
    logic [SAD_W-1:0]  run_min;
    logic [ADDR_W-1:0] run_addr;
    logic              accept, last, better, unused_rsv;

    assign word       = mad_word_t'(mad_res);
    // The reserved bit carries no meaning for this stage.
    assign unused_rsv = word.rsv;

    // A start inside SCAN is a restart, so its in_valid is not counted.
    assign accept     = (state == SCAN) && in_valid && !start;
    assign last       = accept && (cand_count == LAST_CNT - 9'd1);
    // Strict compare keeps the earlier candidate on ties.
    assign better     = word.sad < run_min;

    assign busy       = (state != IDLE);
    assign best_valid = (state == DONE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state: DONE is a single-cycle state; start in DONE is dropped.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SCAN;
            SCAN:    if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: counter, running minimum, and the published result.
    always_ff @(posedge clk) begin
        if (rst) begin
            cand_count <= '0;
            run_min    <= '1;
            run_addr   <= '0;
            best_sad   <= '1;
            best_addr  <= '0;
        end else if (start && state != DONE) begin
            cand_count <= '0;
            run_min    <= '1;
            run_addr   <= '0;
        end else if (accept) begin
            if (cand_count != LAST_CNT) cand_count <= cand_count + 9'd1;
            if (better) begin
                run_min  <= word.sad;
                run_addr <= word.addr;
            end
            // Publish the final minimum, including this last word, on DONE entry.
            if (last) begin
                best_sad  <= better ? word.sad  : run_min;
                best_addr <= better ? word.addr : run_addr;
            end
        end
    end

endmodule
